// File: rtl/mem_stage_access_pkg.sv
// Shared definitions for the M-stage memory access block: opcodes, FSM states, access sizes, decoder.
package mem_stage_access_pkg;

   localparam logic [5:0] OP_LW  = 6'h23;
   localparam logic [5:0] OP_LB  = 6'h20;
   localparam logic [5:0] OP_LBU = 6'h24;
   localparam logic [5:0] OP_LH  = 6'h21;
   localparam logic [5:0] OP_LHU = 6'h25;
   localparam logic [5:0] OP_SW  = 6'h2B;
   localparam logic [5:0] OP_SB  = 6'h28;
   localparam logic [5:0] OP_SH  = 6'h29;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2
   } size_t;

   typedef struct packed {
      logic  is_mem;
      logic  is_load;
      logic  is_unsigned;
      size_t size;
   } mem_op_t;

   function automatic mem_op_t decode_op(input logic [5:0] op);
      mem_op_t d;
      d = '{is_mem: 1'b0, is_load: 1'b0, is_unsigned: 1'b0, size: SZ_WORD};
      case (op)
         OP_LW:   d = '{is_mem: 1'b1, is_load: 1'b1, is_unsigned: 1'b0, size: SZ_WORD};
         OP_LB:   d = '{is_mem: 1'b1, is_load: 1'b1, is_unsigned: 1'b0, size: SZ_BYTE};
         OP_LBU:  d = '{is_mem: 1'b1, is_load: 1'b1, is_unsigned: 1'b1, size: SZ_BYTE};
         OP_LH:   d = '{is_mem: 1'b1, is_load: 1'b1, is_unsigned: 1'b0, size: SZ_HALF};
         OP_LHU:  d = '{is_mem: 1'b1, is_load: 1'b1, is_unsigned: 1'b1, size: SZ_HALF};
         OP_SW:   d = '{is_mem: 1'b1, is_load: 1'b0, is_unsigned: 1'b0, size: SZ_WORD};
         OP_SB:   d = '{is_mem: 1'b1, is_load: 1'b0, is_unsigned: 1'b0, size: SZ_BYTE};
         OP_SH:   d = '{is_mem: 1'b1, is_load: 1'b0, is_unsigned: 1'b0, size: SZ_HALF};
         default: d = '{is_mem: 1'b0, is_load: 1'b0, is_unsigned: 1'b0, size: SZ_WORD};
      endcase
      return d;
   endfunction

endpackage

// File: rtl/mem_stage_access_load_extender.sv
// Selects the addressed byte/half of a read word and sign- or zero-extends it.
// Purely combinational, zero latency, no backpressure.
module load_extender
   import mem_stage_access_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  addr,
   input  logic [1:0]  size,
   input  logic        is_unsigned,
   output logic [31:0] ext
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = rdata[{addr, 3'b000} +: 8];
      half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
      ext      = rdata;
      case (size)
         SZ_BYTE: ext = {{24{byte_sel[7] & ~is_unsigned}}, byte_sel};
         SZ_HALF: ext = {{16{half_sel[15] & ~is_unsigned}}, half_sel};
         default: ext = rdata;
      endcase
   end

endmodule

// File: rtl/mem_stage_access.sv
// M-stage data-memory access: decode, req/ack handshake, lane steering, load extension; stalls upstream until DONE.
// Min 2 stall cycles + 1 DONE cycle per memory op; MISALIGN_EXC_EN turns misaligned word/half accesses into bus errors.
module mem_stage_access
   import mem_stage_access_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] pc_in,
   input  logic [31:0] instruction_in,
   input  logic [31:0] ALUresult_in,
   input  logic [31:0] reg_read_data2_in,
   output logic        stall,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic [31:0] load_data_out,
   output logic        load_valid,
   output logic        bus_error,
   output logic [31:0] error_pc
);

   state_t      state_q, state_d;
   logic [31:0] wait_cnt_q, wait_cnt_d;
   logic        mem_req_q, mem_req_d, mem_we_q, mem_we_d;
   logic [31:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
   logic [3:0]  mem_be_q, mem_be_d;
   logic [31:0] load_data_q, load_data_d, error_pc_q, error_pc_d, pc_q, pc_d;
   logic        load_valid_q, load_valid_d, bus_error_q, bus_error_d;
   logic        is_load_q, is_load_d, uns_q, uns_d;
   logic [1:0]  size_q, size_d, addr_lo_q, addr_lo_d;

   mem_op_t     dec;
   logic        misaligned;
   logic [3:0]  be_new;
   logic [31:0] wdata_new, ext_data;
   logic        unused_instr_bits;

   assign dec               = decode_op(instruction_in[31:26]);
   assign unused_instr_bits = ^instruction_in[25:0];

`ifdef MISALIGN_EXC_EN
   assign misaligned = dec.is_mem &&
                       ((dec.size == SZ_WORD && ALUresult_in[1:0] != 2'b00) ||
                        (dec.size == SZ_HALF && ALUresult_in[0]));
`else
   assign misaligned = 1'b0;
`endif

   // Stores steer the data onto every lane and let the byte enables pick the target.
   always_comb begin
      be_new    = 4'b1111;
      wdata_new = reg_read_data2_in;
      if (!dec.is_load) begin
         case (dec.size)
            SZ_BYTE: begin
               be_new    = 4'b0001 << ALUresult_in[1:0];
               wdata_new = {4{reg_read_data2_in[7:0]}};
            end
            SZ_HALF: begin
               be_new    = ALUresult_in[1] ? 4'b1100 : 4'b0011;
               wdata_new = {2{reg_read_data2_in[15:0]}};
            end
            default: ;
         endcase
      end
   end

   load_extender u_load_extender (
      .rdata       (mem_rdata),
      .addr        (addr_lo_q),
      .size        (size_q),
      .is_unsigned (uns_q),
      .ext         (ext_data)
   );

   always_comb begin
      state_d      = state_q;
      wait_cnt_d   = wait_cnt_q;
      mem_req_d    = mem_req_q;
      mem_we_d     = mem_we_q;
      mem_addr_d   = mem_addr_q;
      mem_be_d     = mem_be_q;
      mem_wdata_d  = mem_wdata_q;
      load_data_d  = load_data_q;
      error_pc_d   = error_pc_q;
      pc_d         = pc_q;
      is_load_d    = is_load_q;
      uns_d        = uns_q;
      size_d       = size_q;
      addr_lo_d    = addr_lo_q;
      load_valid_d = 1'b0;
      bus_error_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (misaligned) begin
               state_d     = ST_DONE;
               bus_error_d = 1'b1;
               error_pc_d  = pc_in;
            end else if (dec.is_mem) begin
               state_d     = ST_REQ;
               wait_cnt_d  = '0;
               mem_req_d   = 1'b1;
               mem_we_d    = ~dec.is_load;
               mem_addr_d  = {ALUresult_in[31:2], 2'b00};
               mem_be_d    = be_new;
               mem_wdata_d = wdata_new;
               pc_d        = pc_in;
               is_load_d   = dec.is_load;
               uns_d       = dec.is_unsigned;
               size_d      = dec.size;
               addr_lo_d   = ALUresult_in[1:0];
            end
         end
         ST_REQ: begin
            // An ack wins over a timeout landing in the same cycle.
            if (mem_ack) begin
               state_d      = ST_DONE;
               mem_req_d    = 1'b0;
               load_data_d  = ext_data;
               load_valid_d = is_load_q;
            end else if (TIMEOUT_CYCLES != 0 && wait_cnt_q + 32'd1 == TIMEOUT_CYCLES) begin
               state_d     = ST_DONE;
               mem_req_d   = 1'b0;
               load_data_d = '0;
               bus_error_d = 1'b1;
               error_pc_d  = pc_q;
            end else begin
               wait_cnt_d = wait_cnt_q + 32'd1;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         wait_cnt_q   <= '0;
         mem_req_q    <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_be_q     <= '0;
         mem_wdata_q  <= '0;
         load_data_q  <= '0;
         error_pc_q   <= '0;
         pc_q         <= '0;
         is_load_q    <= 1'b0;
         uns_q        <= 1'b0;
         size_q       <= '0;
         addr_lo_q    <= '0;
         load_valid_q <= 1'b0;
         bus_error_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         wait_cnt_q   <= wait_cnt_d;
         mem_req_q    <= mem_req_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_be_q     <= mem_be_d;
         mem_wdata_q  <= mem_wdata_d;
         load_data_q  <= load_data_d;
         error_pc_q   <= error_pc_d;
         pc_q         <= pc_d;
         is_load_q    <= is_load_d;
         uns_q        <= uns_d;
         size_q       <= size_d;
         addr_lo_q    <= addr_lo_d;
         load_valid_q <= load_valid_d;
         bus_error_q  <= bus_error_d;
      end
   end

   // Stall is decoded combinationally so a memory op freezes the pipe in its first cycle.
   assign stall         = ~reset & ((state_q == ST_IDLE && dec.is_mem) || state_q == ST_REQ);
   assign mem_req       = mem_req_q;
   assign mem_we        = mem_we_q;
   assign mem_addr      = mem_addr_q;
   assign mem_be        = mem_be_q;
   assign mem_wdata     = mem_wdata_q;
   assign load_data_out = load_data_q;
   assign load_valid    = load_valid_q;
   assign bus_error     = bus_error_q;
   assign error_pc      = error_pc_q;

endmodule

// File: tb/tb_mem_stage_access.sv
// Bench for mem_stage_access: directed scenarios plus randomized ops against an arithmetic reference model.
module tb_mem_stage_access;

   localparam int TMO = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] pc_in, instruction_in, ALUresult_in, reg_read_data2_in;
   logic        stall, mem_req, mem_we, mem_ack, load_valid, bus_error;
   logic [31:0] mem_addr, mem_wdata, mem_rdata, load_data_out, error_pc;
   logic [3:0]  mem_be;

   always #5 clk = ~clk;

   mem_stage_access #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .reset(reset), .pc_in(pc_in), .instruction_in(instruction_in),
      .ALUresult_in(ALUresult_in), .reg_read_data2_in(reg_read_data2_in),
      .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .load_data_out(load_data_out), .load_valid(load_valid), .bus_error(bus_error),
      .error_pc(error_pc)
   );

   int total = 0;
   int bad   = 0;

   // Observations of the most recent run_op
   int          o_stall, o_req, o_lv, o_berr;
   bit          o_done, o_unstable, o_we;
   logic [31:0] o_addr, o_wdata, o_ldata, o_epc;
   logic [3:0]  o_be;
   logic [31:0] last_err_pc = 32'h0;

   // ---------------- reference model ----------------
   function automatic int nbytes(input logic [5:0] op);
      case (op)
         6'h23, 6'h2B:        return 4;
         6'h21, 6'h25, 6'h29: return 2;
         6'h20, 6'h24, 6'h28: return 1;
         default:             return 0;
      endcase
   endfunction

   function automatic bit is_ld(input logic [5:0] op);
      return op == 6'h23 || op == 6'h20 || op == 6'h24 || op == 6'h21 || op == 6'h25;
   endfunction

   function automatic int lane_of(input logic [31:0] addr, input int n);
      int a;
      a = int'(addr & 32'h3);
      return a - (a % n);
   endfunction

   function automatic logic [3:0] m_be(input logic [5:0] op, input logic [31:0] addr);
      int n;
      n = nbytes(op);
      if (is_ld(op)) return 4'hF;
      return 4'(((1 << n) - 1) << lane_of(addr, n));
   endfunction

   function automatic logic [31:0] m_wdata(input logic [5:0] op, input logic [31:0] d);
      longint unsigned m;
      m = (64'd1 << (8 * nbytes(op))) - 1;
      return 32'((d & m) * (64'hFFFF_FFFF / m));
   endfunction

   function automatic logic [31:0] m_load(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] rd);
      longint m, v;
      int n;
      n = nbytes(op);
      m = (64'd1 << (8 * n)) - 1;
      v = longint'((rd >> (8 * lane_of(addr, n)))) & m;
      if ((op == 6'h20 || op == 6'h21) && v > m / 2) v = v - (m + 1);
      return 32'(v);
   endfunction

   function automatic bit m_misal(input logic [5:0] op, input logic [31:0] addr);
`ifdef MISALIGN_EXC_EN
      return nbytes(op) > 1 && (int'(addr & 32'h3) % nbytes(op)) != 0;
`else
      return (op == 6'h3F) && (addr == 32'h1);
`endif
   endfunction

   // Drives one M-stage instruction until it advances; called and returns just after a rising edge.
   task automatic run_op(input logic [31:0] pc, input logic [31:0] ins, input logic [31:0] addr,
                         input logic [31:0] d, input int waits, input logic [31:0] rd);
      pc_in = pc; instruction_in = ins; ALUresult_in = addr; reg_read_data2_in = d;
      o_stall = 0; o_req = 0; o_lv = 0; o_berr = 0; o_done = 0; o_unstable = 0;
      for (int cyc = 0; cyc < 40; cyc++) begin
         @(negedge clk);
         if (load_valid) begin o_lv++; o_ldata = load_data_out; end
         if (bus_error) o_berr++;
         if (mem_req) begin
            if (o_req == 0) begin
               o_addr = mem_addr; o_be = mem_be; o_wdata = mem_wdata; o_we = mem_we;
            end else if (mem_addr !== o_addr || mem_be !== o_be || mem_wdata !== o_wdata || mem_we !== o_we) begin
               o_unstable = 1;
            end
            if (o_req == waits) begin mem_ack = 1'b1; mem_rdata = rd; end
            o_req++;
         end
         if (stall) o_stall++;
         else begin o_done = 1; o_epc = error_pc; end
         @(posedge clk); #1;
         mem_ack = 1'b0; mem_rdata = $urandom;
         if (o_done) break;
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset;
      reset = 1'b1; mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
      pc_in = 32'h100; instruction_in = {6'h23, 26'h0}; ALUresult_in = 32'h8; reg_read_data2_in = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      total++;
      if ({stall, mem_req, mem_we, mem_addr, mem_be, mem_wdata, load_data_out, load_valid, bus_error, error_pc} !== '0) begin
         bad++; $display("FAIL reset_outputs got stall=%b req=%b addr=%h be=%h epc=%h exp all zero", stall, mem_req, mem_addr, mem_be, error_pc);
      end
      @(posedge clk); #1;
      reset = 1'b0; mem_ack = 1'b0;
   endtask

   task automatic test_lw;
      run_op(32'h200, {6'h23, 26'h0}, 32'h10, 32'h0, 2, 32'hDEAD_BEEF);
      total++; if (o_addr !== 32'h10) begin bad++; $display("FAIL lw_addr got=%h exp=%h", o_addr, 32'h10); end
      total++; if (o_be !== 4'b1111) begin bad++; $display("FAIL lw_be got=%b exp=1111", o_be); end
      total++; if (o_stall !== 4) begin bad++; $display("FAIL lw_stall got=%0d exp=4", o_stall); end
      total++; if (o_lv !== 1) begin bad++; $display("FAIL lw_load_valid got=%0d exp=1", o_lv); end
      total++; if (o_ldata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL lw_data got=%h exp=DEADBEEF", o_ldata); end
   endtask

   task automatic test_sb;
      run_op(32'h204, {6'h28, 26'h0}, 32'h13, 32'h0000_00A5, 0, 32'h0);
      total++; if (o_be !== 4'b1000) begin bad++; $display("FAIL sb_be got=%b exp=1000", o_be); end
      total++; if (o_wdata !== 32'hA5A5_A5A5) begin bad++; $display("FAIL sb_wdata got=%h exp=A5A5A5A5", o_wdata); end
      total++; if (o_we !== 1'b1) begin bad++; $display("FAIL sb_we got=%b exp=1", o_we); end
      total++; if (o_stall !== 2) begin bad++; $display("FAIL sb_stall got=%0d exp=2", o_stall); end
      total++; if (o_lv !== 0) begin bad++; $display("FAIL sb_load_valid got=%0d exp=0", o_lv); end
   endtask

   task automatic test_lh_lhu;
      run_op(32'h208, {6'h21, 26'h0}, 32'h2, 32'h0, 1, 32'h8001_1234);
      total++; if (o_ldata !== 32'hFFFF_8001) begin bad++; $display("FAIL lh_data got=%h exp=FFFF8001", o_ldata); end
      total++; if (o_we !== 1'b0) begin bad++; $display("FAIL lh_we got=%b exp=0", o_we); end
      run_op(32'h20C, {6'h25, 26'h0}, 32'h2, 32'h0, 1, 32'h8001_1234);
      total++; if (o_ldata !== 32'h0000_8001) begin bad++; $display("FAIL lhu_data got=%h exp=00008001", o_ldata); end
   endtask

   task automatic test_add_then_sw;
      run_op(32'h300, {6'h00, 26'h0221820}, 32'h1234, 32'h0, 0, 32'h0);
      total++; if (o_stall !== 0 || o_req !== 0) begin bad++; $display("FAIL add_nostall got stall=%0d req=%0d exp 0/0", o_stall, o_req); end
      run_op(32'h304, {6'h2B, 26'h0}, 32'h4, 32'hCAFE_F00D, 0, 32'h0);
      total++; if (o_req !== 1) begin bad++; $display("FAIL sw_req_count got=%0d exp=1", o_req); end
      total++; if (o_wdata !== 32'hCAFE_F00D || o_be !== 4'hF || o_addr !== 32'h4) begin
         bad++; $display("FAIL sw_bus got wdata=%h be=%b addr=%h exp CAFEF00D/1111/4", o_wdata, o_be, o_addr);
      end
      run_op(32'h308, {6'h08, 26'h0}, 32'h4, 32'h0, 0, 32'h0);
      total++; if (o_req !== 0 || o_stall !== 0) begin bad++; $display("FAIL sw_no_reissue got req=%0d stall=%0d exp 0/0", o_req, o_stall); end
   endtask

   task automatic test_timeout;
      run_op(32'h400, {6'h23, 26'h0}, 32'h20, 32'h0, 100, 32'h0);
      total++; if (o_req !== TMO) begin bad++; $display("FAIL tmo_req_cycles got=%0d exp=%0d", o_req, TMO); end
      total++; if (o_berr !== 1) begin bad++; $display("FAIL tmo_bus_error got=%0d exp=1", o_berr); end
      total++; if (o_epc !== 32'h400) begin bad++; $display("FAIL tmo_error_pc got=%h exp=400", o_epc); end
      total++; if (o_lv !== 0 || load_data_out !== 32'h0) begin bad++; $display("FAIL tmo_load got lv=%0d data=%h exp 0/0", o_lv, load_data_out); end
      last_err_pc = 32'h400;
      run_op(32'h404, {6'h00, 26'h0}, 32'h0, 32'h0, 0, 32'h0);
      total++; if (o_stall !== 0 || o_berr !== 0) begin bad++; $display("FAIL tmo_resume got stall=%0d berr=%0d exp 0/0", o_stall, o_berr); end
   endtask

   task automatic test_misalign;
      run_op(32'h500, {6'h23, 26'h0}, 32'h6, 32'h0, 0, 32'h1122_3344);
`ifdef MISALIGN_EXC_EN
      total++; if (o_req !== 0) begin bad++; $display("FAIL misal_req got=%0d exp=0", o_req); end
      total++; if (o_berr !== 1 || o_stall !== 1 || o_lv !== 0) begin bad++; $display("FAIL misal_err got berr=%0d stall=%0d lv=%0d exp 1/1/0", o_berr, o_stall, o_lv); end
      total++; if (o_epc !== 32'h500) begin bad++; $display("FAIL misal_epc got=%h exp=500", o_epc); end
      last_err_pc = 32'h500;
`else
      total++; if (o_addr !== 32'h4 || o_req !== 1) begin bad++; $display("FAIL misal_aligned got addr=%h req=%0d exp 4/1", o_addr, o_req); end
      total++; if (o_ldata !== 32'h1122_3344 || o_berr !== 0) begin bad++; $display("FAIL misal_data got=%h berr=%0d exp 11223344/0", o_ldata, o_berr); end
`endif
   endtask

   task automatic test_ack_ignored;
      pc_in = 32'h600; instruction_in = {6'h0D, 26'h0}; mem_ack = 1'b1; mem_rdata = 32'h5555_5555;
      @(negedge clk);
      total++; if (mem_req !== 1'b0 || stall !== 1'b0) begin bad++; $display("FAIL idle_ack got req=%b stall=%b exp 0/0", mem_req, stall); end
      @(posedge clk); #1;
      mem_ack = 1'b0;
      @(negedge clk);
      total++; if (load_valid !== 1'b0 || mem_req !== 1'b0) begin bad++; $display("FAIL idle_ack_after got lv=%b req=%b exp 0/0", load_valid, mem_req); end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_midreq;
      pc_in = 32'h700; instruction_in = {6'h23, 26'h0}; ALUresult_in = 32'h40;
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(negedge clk);
      total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL midreq_req got=%b exp=1", mem_req); end
      reset = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      total++;
      if ({stall, mem_req, mem_we, mem_addr, mem_be, mem_wdata, load_data_out, load_valid, bus_error, error_pc} !== '0) begin
         bad++; $display("FAIL midreq_reset got stall=%b req=%b addr=%h be=%h epc=%h exp all zero", stall, mem_req, mem_addr, mem_be, error_pc);
      end
      last_err_pc = 32'h0;
      @(posedge clk); #1;
      reset = 1'b0; instruction_in = 32'h0; mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
      @(negedge clk);
      total++; if (mem_req !== 1'b0 || stall !== 1'b0) begin bad++; $display("FAIL late_ack got req=%b stall=%b exp 0/0", mem_req, stall); end
      @(posedge clk); #1;
      mem_ack = 1'b0;
      @(negedge clk);
      total++; if (load_valid !== 1'b0 || load_data_out !== 32'h0) begin bad++; $display("FAIL late_ack_data got lv=%b data=%h exp 0/0", load_valid, load_data_out); end
      @(posedge clk); #1;
   endtask

   task automatic test_random_back_to_back;
      logic [5:0]  ops [11];
      logic [5:0]  op;
      logic [31:0] pc, addr, d, rd;
      int          waits, n, e_req;
      bit          tmo, mis;
      ops = '{6'h23, 6'h20, 6'h24, 6'h21, 6'h25, 6'h2B, 6'h28, 6'h29, 6'h00, 6'h08, 6'h04};
      for (int i = 0; i < 60; i++) begin
         op    = ops[$urandom_range(0, 10)];
         pc    = 32'h1000 + 32'(i * 4);
         addr  = $urandom; d = $urandom; rd = $urandom;
         waits = $urandom_range(0, 5);
         n     = nbytes(op);
         mis   = (n > 0) && m_misal(op, addr);
         tmo   = (n > 0) && !mis && waits >= TMO;
         e_req = (n == 0 || mis) ? 0 : (tmo ? TMO : waits + 1);
         run_op(pc, {op, 26'(d)}, addr, d, waits, rd);
         if (mis || tmo) last_err_pc = pc;
         total++; if (o_done !== 1'b1) begin bad++; $display("FAIL rnd%0d_done got=%b exp=1", i, o_done); end
         total++; if (o_req !== e_req) begin bad++; $display("FAIL rnd%0d_req got=%0d exp=%0d", i, o_req, e_req); end
         total++; if (o_stall !== (n == 0 ? 0 : e_req + 1)) begin bad++; $display("FAIL rnd%0d_stall got=%0d req=%0d", i, o_stall, e_req); end
         total++; if (o_berr !== int'(mis || tmo)) begin bad++; $display("FAIL rnd%0d_berr got=%0d exp=%0d", i, o_berr, mis || tmo); end
         total++; if (o_epc !== last_err_pc) begin bad++; $display("FAIL rnd%0d_epc got=%h exp=%h", i, o_epc, last_err_pc); end
         total++; if (o_lv !== int'(is_ld(op) && e_req > 0 && !tmo)) begin bad++; $display("FAIL rnd%0d_lv got=%0d", i, o_lv); end
         if (e_req > 0) begin
            total++;
            if (o_addr !== (addr & 32'hFFFF_FFFC) || o_be !== m_be(op, addr) || o_we !== !is_ld(op) || o_unstable) begin
               bad++; $display("FAIL rnd%0d_bus op=%h got addr=%h be=%b we=%b unstable=%b exp addr=%h be=%b", i, op, o_addr, o_be, o_we, o_unstable, addr & 32'hFFFF_FFFC, m_be(op, addr));
            end
            if (!is_ld(op)) begin
               total++; if (o_wdata !== m_wdata(op, d)) begin bad++; $display("FAIL rnd%0d_wdata got=%h exp=%h", i, o_wdata, m_wdata(op, d)); end
            end else if (!tmo) begin
               total++; if (o_ldata !== m_load(op, addr, rd)) begin bad++; $display("FAIL rnd%0d_load op=%h got=%h exp=%h", i, op, o_ldata, m_load(op, addr, rd)); end
            end
         end
      end
   endtask

   initial begin
      mem_ack = 1'b0; mem_rdata = 32'h0; reset = 1'b1;
      pc_in = 32'h0; instruction_in = 32'h0; ALUresult_in = 32'h0; reg_read_data2_in = 32'h0;
      test_reset;
      test_lw;
      test_sb;
      test_lh_lhu;
      test_add_then_sw;
      test_timeout;
      test_misalign;
      test_ack_ignored;
      test_reset_midreq;
      test_random_back_to_back;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

endmodule

// File: doc/mem_stage_access.md
Name: mem_stage_access

Overview:
- M-stage consumer of the EX/MEM pipeline register.
- Takes pc, instruction, ALU result (address) and rs2/rt store data, decodes the memory operation, and runs a req/ack handshake to a variable-latency data memory.
- Generates byte enables and replicated write data; sign/zero-extends load data.
- Asserts a stall that freezes F/D/E/M registers until the access completes.

Parameters:
- TIMEOUT_CYCLES, 255, max cycles in REQ waiting for mem_ack before aborting with bus_error (0 = no timeout)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- pc_in  input  32  PC of the instruction held in the M register
- instruction_in  input  32  instruction held in the M register
- ALUresult_in  input  32  effective byte address
- reg_read_data2_in  input  32  store data (rt)
- stall  output  1  freeze upstream pipeline registers; M register holds its value
- mem_req  output  1  access request, registered
- mem_we  output  1  write access
- mem_addr  output  32  word address {ALUresult_in[31:2],2'b00}, registered
- mem_be  output  4  byte enables
- mem_wdata  output  32  replicated store data
- mem_ack  input  1  memory completion, valid only while mem_req=1
- mem_rdata  input  32  read word, valid with mem_ack
- load_data_out  output  32  extended load result, valid in DONE
- load_valid  output  1  high for exactly the DONE cycle of a load
- bus_error  output  1  one-cycle pulse on timeout (or misalignment, see option)
- error_pc  output  32  pc_in of the faulting access, held until the next error

Behaviour:
- Decoding, opcode = instruction[31:26]:
  - loads: lw 0x23, lb 0x20, lbu 0x24, lh 0x21, lhu 0x25
  - stores: sw 0x2B, sb 0x28, sh 0x29
  - anything else is a non-memory instruction.
- FSM states IDLE, REQ, DONE.
- IDLE:
  - Non-memory instruction: stall=0, no request; the instruction passes with zero added latency.
  - Memory op: stall=1, latch addr/be/wdata/we/opcode/pc, next state REQ.
- REQ:
  - mem_req=1, stall=1; all mem_* outputs stable until ack.
  - On mem_ack: capture the extended load data into a register, next state DONE.
  - Ack in the first REQ cycle is legal.
  - Wait counter increments each REQ cycle without ack. When it reaches TIMEOUT_CYCLES: drop mem_req, pulse bus_error, go DONE with load_data_out=0.
- DONE:
  - stall=0 for one cycle so the M register advances; load_valid=1 if the op was a load; next state IDLE.
- Minimum cost per memory op is 2 stall cycles + 1 DONE cycle.
- Byte enables and write data:
  - sw: be=1111, wdata=d.
  - sh: be = addr[1] ? 1100 : 0011, wdata={d[15:0],d[15:0]}.
  - sb: be = 0001<<addr[1:0], wdata={4{d[7:0]}}.
  - Loads: be=1111, we=0.
- Load extraction:
  - lb/lbu: byte addr[1:0], sign/zero extend.
  - lh/lhu: half addr[1], sign/zero extend.
  - lw: whole word.
- mem_ack while in IDLE or DONE is ignored, e.g. a late ack after reset.
- Reset, including mid-REQ: state=IDLE, counter=0.
  - All outputs 0: stall, mem_req, mem_we, mem_addr, mem_be, mem_wdata, load_data_out, load_valid, bus_error, error_pc.
  - mem_req deasserts at the resetting edge.
- Back-to-back memory instructions: after DONE the new M contents are decoded in IDLE the next cycle. An instruction is never issued twice, because DONE always advances the M register.

Optional Feature:
- MISALIGN_EXC_EN defined:
  - In IDLE, lw/sw with addr[1:0]!=0, or lh/lhu/sh with addr[0]=1, issue no request and go straight to DONE.
  - bus_error pulses, error_pc=pc_in, load_valid=0, stall=1 for 1 cycle only.
- Undefined: low address bits are used as described above with no check; misaligned lw/sw access the aligned word.

Decomposition:
- Shared package holds:
  - opcode constants (OP_LW, OP_LB, OP_LBU, OP_LH, OP_LHU, OP_SW, OP_SB, OP_SH)
  - FSM state encoding (ST_IDLE, ST_REQ, ST_DONE)
  - memory size codes (SZ_BYTE, SZ_HALF, SZ_WORD)
- Sub-module load_extender (combinational): inputs rdata, addr[1:0], size, unsigned flag; output 32-bit extended value.

Test Plan:
- lw, addr 0x0000_0010, ack after 3 cycles with rdata 0xDEADBEEF -> mem_addr=0x10, be=1111, stall high 4 cycles, then DONE with load_valid=1, load_data_out=0xDEADBEEF.
- sb, addr 0x13, rt=0x0000_00A5, ack in first REQ cycle -> be=1000, wdata=0xA5A5A5A5, we=1, stall 2 cycles.
- lh, addr 0x2, rdata 0x8001_1234 -> load_data_out=0xFFFF8001; lhu same access -> 0x00008001.
- add followed by sw, addr 0x4 -> add sees stall=0; sw then stalls and issues exactly one request.
- Reset asserted in the 2nd REQ cycle, ack arrives one cycle later -> all outputs 0, state IDLE, late ack ignored.
- TIMEOUT_CYCLES=4, no ack -> mem_req drops after 4 REQ cycles, bus_error pulses once, error_pc=pc_in, pipeline resumes. With MISALIGN_EXC_EN: lw at 0x6 -> no mem_req, bus_error pulse.
